// File: rtl/car_lane_pkg.sv
// ============================================================================
//  Module   : car_lane_pkg
//  Purpose  : Shared state encoding and default dimensions for the car lane.
//  Revision : 1.0  initial multi-car lane
// ============================================================================
`default_nettype none

package car_lane_pkg;

    // Lane control states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } lane_state_t;

    localparam int DEFAULT_GRID_COLS = 20;
    localparam int DEFAULT_X_WIDTH   = 5;

    // Half a second at the 25 MHz system clock
    localparam int STEP_HALF_SEC     = 12500000;

endpackage : car_lane_pkg

`default_nettype wire

// File: rtl/car_lane_tick_divider.sv
// ============================================================================
//  Module   : tick_divider
//  Purpose  : Programmable step-period counter. Produces a one-cycle strobe
//             every latched-period clocks; the period is re-sampled (and
//             clamped to MIN_PERIOD) on clear and at every strobe.
//  Revision : 1.0  initial
// ============================================================================
`default_nettype none

module tick_divider
    import car_lane_pkg::*;
#(
    parameter int PERIOD_WIDTH = 24,
    parameter int MIN_PERIOD   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    enable,
    input  logic                    complete,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    strobe
);

    localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(MIN_PERIOD);

    logic [PERIOD_WIDTH-1:0] count;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [PERIOD_WIDTH-1:0] period_clamped;

    assign period_clamped = (period < MIN_P) ? MIN_P : period;

    // A boundary that is already due may still finish while counting is
    // being paused (complete), but a clear always suppresses it.
    assign strobe = !clear && (enable || complete) &&
                    (count == period_q - PERIOD_WIDTH'(1));

    // Counter and period latch; count always stays below period_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            period_q <= MIN_P;
        end else if (clear || strobe) begin
            count    <= '0;
            period_q <= period_clamped;
        end else if (enable) begin
            count    <= count + PERIOD_WIDTH'(1);
        end
    end

endmodule : tick_divider

`default_nettype wire

// File: rtl/car_lane.sv
// ============================================================================
//  Module   : car_lane
//  Purpose  : Frogger lane holding NUM_CARS cars that advance one cell per
//             programmable step period, with pause, reload, direction select
//             and a registered frog collision flag.
//  Revision : 1.0  initial multi-car lane
// ============================================================================
`default_nettype none

module car_lane
    import car_lane_pkg::*;
#(
    parameter int NUM_CARS     = 3,
    parameter int X_WIDTH      = DEFAULT_X_WIDTH,
    parameter int GRID_COLS    = DEFAULT_GRID_COLS,
    parameter int PERIOD_WIDTH = 24,
    parameter int MIN_PERIOD   = 2
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_L,
    input  logic                        i_Load,
    input  logic [NUM_CARS*X_WIDTH-1:0] i_Start_X,
    input  logic                        i_Enable,
    input  logic [PERIOD_WIDTH-1:0]     i_Period,
    input  logic                        i_Dir,
    input  logic [X_WIDTH-1:0]          i_Frog_X,
    input  logic                        i_Frog_On_Lane,
    output logic [NUM_CARS*X_WIDTH-1:0] o_Car_X,
    output logic                        o_Step,
    output logic                        o_Active,
    output logic                        o_Hit
);

    localparam logic [X_WIDTH-1:0] LAST_X    = X_WIDTH'(GRID_COLS - 1);
    localparam logic [X_WIDTH:0]   COLS_EXT  = (X_WIDTH + 1)'(GRID_COLS);

    if (GRID_COLS > (1 << X_WIDTH)) begin : g_cols_check
        $error("car_lane: GRID_COLS does not fit in X_WIDTH bits");
    end

    if (NUM_CARS < 1 || NUM_CARS > 8) begin : g_cars_check
        $error("car_lane: NUM_CARS must be in 1..8");
    end

    lane_state_t          state;
    logic                 tick_en;
    logic                 run_now;
    logic                 step_now;
    logic [NUM_CARS-1:0]  car_match;

    assign tick_en = (state != S_IDLE) && i_Enable;
    assign run_now = (state == S_RUN);

    tick_divider #(
        .PERIOD_WIDTH (PERIOD_WIDTH),
        .MIN_PERIOD   (MIN_PERIOD)
    ) u_tick_divider (
        .clk      (i_Clk),
        .rst_n    (i_Rst_L),
        .clear    (i_Load),
        .enable   (tick_en),
        .complete (run_now),
        .period   (i_Period),
        .strobe   (step_now)
    );

    for (genvar k = 0; k < NUM_CARS; k++) begin : g_car
        logic [X_WIDTH-1:0] start_x;
        logic [X_WIDTH-1:0] pos;

        assign start_x = i_Start_X[k*X_WIDTH +: X_WIDTH];

        // Car position: load (out-of-range starts park at 0), else wrap-step
        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                pos <= '0;
            end else if (i_Load) begin
                pos <= ({1'b0, start_x} >= COLS_EXT) ? '0 : start_x;
            end else if (step_now) begin
                if (i_Dir) begin
                    pos <= (pos == '0) ? LAST_X : pos - X_WIDTH'(1);
                end else begin
                    pos <= (pos == LAST_X) ? '0 : pos + X_WIDTH'(1);
                end
            end
        end

        assign o_Car_X[k*X_WIDTH +: X_WIDTH] = pos;
        assign car_match[k]                  = (pos == i_Frog_X);
    end

    // Lane control FSM with registered step, active and hit outputs
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state    <= S_IDLE;
            o_Step   <= 1'b0;
            o_Active <= 1'b0;
            o_Hit    <= 1'b0;
        end else begin
            o_Hit <= i_Frog_On_Lane && (|car_match);
            if (i_Load) begin
                state    <= S_RUN;
                o_Step   <= 1'b0;
                o_Active <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        o_Step   <= 1'b0;
                        o_Active <= 1'b0;
                    end
                    S_RUN, S_PAUSE: begin
                        o_Step   <= step_now;
                        o_Active <= 1'b1;
                        state    <= i_Enable ? S_RUN : S_PAUSE;
                    end
                    default: begin
                        state    <= S_IDLE;
                        o_Step   <= 1'b0;
                        o_Active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : car_lane

`default_nettype wire

// File: tb/tb_car_lane.sv
// ============================================================================
//  Module   : tb_car_lane
//  Purpose  : Self-checking bench for car_lane: vector table, directed
//             corner-case sequences and a randomized run against a
//             cell-arithmetic reference model.
//  Revision : 1.0  initial
// ============================================================================
`default_nettype none

module tb_car_lane;

    localparam int NC = 3;
    localparam int XW = 5;
    localparam int GC = 20;
    localparam int PW = 24;
    localparam int MINP = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load;
    logic [NC*XW-1:0]  start_x;
    logic              enable;
    logic [PW-1:0]     period;
    logic              dir;
    logic [XW-1:0]     frog_x;
    logic              on_lane;
    logic [NC*XW-1:0]  car_x;
    logic              step;
    logic              active;
    logic              hit;

    car_lane #(
        .NUM_CARS     (NC),
        .X_WIDTH      (XW),
        .GRID_COLS    (GC),
        .PERIOD_WIDTH (PW),
        .MIN_PERIOD   (MINP)
    ) dut (
        .i_Clk          (clk),
        .i_Rst_L        (rst_n),
        .i_Load         (load),
        .i_Start_X      (start_x),
        .i_Enable       (enable),
        .i_Period       (period),
        .i_Dir          (dir),
        .i_Frog_X       (frog_x),
        .i_Frog_On_Lane (on_lane),
        .o_Car_X        (car_x),
        .o_Step         (step),
        .o_Active       (active),
        .o_Hit          (hit)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: cars as integer cells, time as clocks since last step
    int m_pos[NC];
    int m_cnt;
    int m_per;
    int m_mode;          // 0 idle, 1 moving, 2 paused
    bit m_step;
    bit m_act;
    bit m_hit;

    typedef struct {
        logic             ld;
        logic [NC*XW-1:0] st;
        logic             en;
        logic [PW-1:0]    per;
        logic             dr;
        logic [XW-1:0]    fx;
        logic             on;
        logic             exp_step;
        logic [NC*XW-1:0] exp_x;
        logic             exp_hit;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [NC*XW-1:0] pack3(input int a, input int b, input int c);
        return {XW'(c), XW'(b), XW'(a)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) m_pos[k] = 0;
        m_cnt = 0; m_per = MINP; m_mode = 0;
        m_step = 0; m_act = 0; m_hit = 0;
    endtask

    function automatic int clamp_p(input logic [PW-1:0] p);
        return (int'(p) < MINP) ? MINP : int'(p);
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic model_update();
        bit hn = 0;
        bit due;
        for (int k = 0; k < NC; k++)
            if (m_pos[k] == int'(frog_x)) hn = on_lane;
        if (load) begin
            for (int k = 0; k < NC; k++) begin
                int s = int'(start_x[k*XW +: XW]);
                m_pos[k] = (s < GC) ? s : 0;
            end
            m_cnt = 0; m_per = clamp_p(period); m_mode = 1; m_step = 0;
        end else if (m_mode != 0) begin
            due = (m_cnt == m_per - 1) && (enable || m_mode == 1);
            if (due) begin
                for (int k = 0; k < NC; k++)
                    m_pos[k] = dir ? (m_pos[k] + GC - 1) % GC : (m_pos[k] + 1) % GC;
                m_cnt = 0; m_per = clamp_p(period);
            end else if (enable) begin
                m_cnt++;
            end
            m_step = due;
            m_mode = enable ? 1 : 2;
        end else begin
            m_step = 0;
        end
        m_act = (m_mode != 0);
        m_hit = hn;
    endtask

    function automatic logic [NC*XW-1:0] model_pack();
        logic [NC*XW-1:0] v = '0;
        for (int k = 0; k < NC; k++) v[k*XW +: XW] = XW'(m_pos[k]);
        return v;
    endfunction

    // One clock: model advance, DUT edge, compare away from the edge
    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
        check("model_car_x",  32'(car_x),  32'(model_pack()));
        check("model_step",   32'(step),   32'(m_step));
        check("model_active", 32'(active), 32'(m_act));
        check("model_hit",    32'(hit),    32'(m_hit));
    endtask

    task automatic run_to_step(input string name, input int expect_n);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!step && n < 20);
        check(name, 32'(n), 32'(expect_n));
    endtask

    initial begin
        rst_n = 1'b0; load = 0; start_x = '0; enable = 0; period = 24'd4;
        dir = 0; frog_x = 5'd11; on_lane = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_car_x",  32'(car_x),  0);
        check("rst_step",   32'(step),   0);
        check("rst_active", 32'(active), 0);
        check("rst_hit",    32'(hit),    0);
        enable = 1;
        repeat (3) tick();

        // Vector table: load {2,10,19}, period 4, increasing, frog at 11
        for (int i = 0; i < 10; i++) begin
            tbl[i].ld = (i == 0); tbl[i].st = pack3(2, 10, 19); tbl[i].en = 1;
            tbl[i].per = 24'd4; tbl[i].dr = 0; tbl[i].fx = 5'd11;
            tbl[i].on = (i != 6); tbl[i].exp_step = (i == 4 || i == 8);
            tbl[i].exp_x = (i < 4) ? pack3(2, 10, 19) :
                           (i < 8) ? pack3(3, 11, 0) : pack3(4, 12, 1);
            tbl[i].exp_hit = (i == 5 || i == 7 || i == 8);
        end
        for (int i = 0; i < 10; i++) begin
            load = tbl[i].ld; start_x = tbl[i].st; enable = tbl[i].en;
            period = tbl[i].per; dir = tbl[i].dr; frog_x = tbl[i].fx; on_lane = tbl[i].on;
            tick();
            check("tbl_step",  32'(step),  32'(tbl[i].exp_step));
            check("tbl_car_x", 32'(car_x), 32'(tbl[i].exp_x));
            check("tbl_hit",   32'(hit),   32'(tbl[i].exp_hit));
        end
        on_lane = 0;

        // Decreasing direction with wrap at 0
        load = 1; start_x = pack3(0, 5, 1); dir = 1; period = 24'd3;
        tick();
        load = 0;
        run_to_step("dec_gap1", 3);
        check("dec_pos1", 32'(car_x), 32'(pack3(19, 4, 0)));
        run_to_step("dec_gap2", 3);
        check("dec_pos2", 32'(car_x), 32'(pack3(18, 3, 19)));

        // Period clamp and deferred period change
        load = 1; start_x = pack3(0, 0, 0); dir = 0; period = 24'd0;
        tick();
        load = 0;
        run_to_step("clamp_gap1", 2);
        period = 24'd6;
        run_to_step("clamp_gap2", 2);
        run_to_step("new_gap", 6);

        // Pause at count 2 of period 4, then resume
        load = 1; start_x = pack3(1, 2, 3); period = 24'd4;
        tick();
        load = 0;
        tick(); tick();
        enable = 0;
        for (int i = 0; i < 10; i++) tick();
        check("pause_car_x",  32'(car_x),  32'(pack3(1, 2, 3)));
        check("pause_active", 32'(active), 1);
        enable = 1;
        run_to_step("resume_gap", 2);
        check("resume_pos", 32'(car_x), 32'(pack3(2, 3, 4)));

        // Load collides with a due step; out-of-range start parks at 0
        tick(); tick(); tick();
        load = 1; start_x = pack3(25, 7, 8);
        tick();
        load = 0;
        check("load_wins_step", 32'(step),  0);
        check("load_wins_x",    32'(car_x), 32'(pack3(0, 7, 8)));

        // Reset in the middle of a count
        frog_x = 5'd7; on_lane = 1;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_car_x",  32'(car_x),  0);
        check("midrst_step",   32'(step),   0);
        check("midrst_active", 32'(active), 0);
        check("midrst_hit",    32'(hit),    0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        on_lane = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_step", 32'(step), 0);
        end

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            load    = ($urandom_range(0, 29) == 0);
            start_x = NC*XW'($urandom);
            enable  = ($urandom_range(0, 4) != 0);
            period  = PW'($urandom_range(0, 5));
            dir     = 1'($urandom);
            frog_x  = XW'($urandom_range(0, GC - 1));
            on_lane = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_car_lane

`default_nettype wire

// File: doc/car_lane.md
Name: car_lane

Overview:
- Parametrised traffic lane for the Frogger-style playfield; replaces the single fixed-speed car with up to NUM_CARS cars sharing one lane.
- Provides a runtime-programmable step period, selectable direction, pause and reload, and a registered frog collision flag.
- Sits between the game controller (load, enable, speed, frog position) and the sprite renderer, which consumes the packed car X positions.

Parameters:
- NUM_CARS, 3, number of cars in the lane (1..8)
- X_WIDTH, 5, width of one X coordinate
- GRID_COLS, 20, lane width in cells; legal X is 0..GRID_COLS-1
- PERIOD_WIDTH, 24, width of the step-period counter
- MIN_PERIOD, 2, smallest honoured period; smaller requests are clamped up to it

Ports:
- i_Clk, in, 1, 25 MHz system clock
- i_Rst_L, in, 1, asynchronous active-low reset
- i_Load, in, 1, one-cycle strobe; loads start positions and enters RUN
- i_Start_X, in, NUM_CARS*X_WIDTH, packed start X values; car k occupies bits [k*X_WIDTH +: X_WIDTH]
- i_Enable, in, 1, level signal; 1 = cars move, 0 = pause
- i_Period, in, PERIOD_WIDTH, clocks per step (12500000 = 0.5 s); sampled at each step boundary and on load
- i_Dir, in, 1, 0 = increasing X, 1 = decreasing X; sampled at each step
- i_Frog_X, in, X_WIDTH, frog column
- i_Frog_On_Lane, in, 1, frog occupies this lane's row
- o_Car_X, out, NUM_CARS*X_WIDTH, packed current car positions
- o_Step, out, 1, one-cycle pulse on the clock in which positions update
- o_Active, out, 1, high in RUN or PAUSE
- o_Hit, out, 1, registered collision flag

Behaviour:
- Reset (async assert, sync release): state IDLE, all o_Car_X = 0, tick counter = 0, o_Step = 0, o_Active = 0, o_Hit = 0.
- States:
  - IDLE: cars held, no steps. i_Load moves to RUN.
  - RUN: tick counter increments while i_Enable = 1. i_Enable = 0 moves to PAUSE.
  - PAUSE: counter and positions hold. i_Enable = 1 returns to RUN with the count resumed, not restarted.
  - i_Load in any state: reload and go to RUN.
- Load:
  - Car k takes its start X, or 0 if the start X is >= GRID_COLS.
  - Tick counter clears.
  - Latched period becomes max(i_Period, MIN_PERIOD).
  - No o_Step in the load cycle.
- Step:
  - In RUN, when the counter equals latched period - 1, the counter wraps to 0 and o_Step pulses in that same cycle.
  - Every car moves one cell in the sampled direction on that cycle, so steps occur exactly every P clocks.
  - The period is re-latched at this boundary.
- Wrap:
  - Increasing direction: GRID_COLS-1 -> 0.
  - Decreasing direction: 0 -> GRID_COLS-1.
  - No intermediate value ever reaches GRID_COLS.
- Simultaneous events:
  - i_Load wins over a step due in the same cycle.
  - A step due while i_Enable falls still completes, then the block enters PAUSE.
- Collision:
  - o_Hit(t+1) = i_Frog_On_Lane(t) AND (any o_Car_X(t) == i_Frog_X(t)).
  - Evaluated on registered positions; one-cycle latency; valid in all states, including IDLE.
- Reset mid-step discards all state immediately. o_Active falls asynchronously with reset.
- Arithmetic: all X math in X_WIDTH bits; compare against GRID_COLS-1 before incrementing, so no overflow. Requires GRID_COLS <= 2**X_WIDTH; elaboration-time check.

Decomposition:
- Package car_lane_pkg:
  - state encoding: S_IDLE, S_RUN, S_PAUSE
  - default GRID_COLS and X_WIDTH
  - constant STEP_HALF_SEC = 12500000
- Sub-module tick_divider:
  - programmable period counter with enable, clear, period latch and MIN_PERIOD clamp
  - outputs the single-cycle strobe
- car_lane instantiates one tick_divider and a generate loop of NUM_CARS position registers plus the collision OR-reduce.

Test Plan:
- Reset with i_Rst_L low mid-count -> all outputs 0 immediately; state IDLE; no o_Step after release without i_Load.
- Load {2,10,19}, period 4, dir 0, enable 1 -> o_Step every 4 clocks; positions {3,11,0}, then {4,12,1}.
- Load {0,5,1}, dir 1, period 3 -> first step gives {19,4,0}; next gives {18,3,19}.
- Period 0 requested at load -> clamped to MIN_PERIOD=2; o_Step every 2 clocks; change i_Period to 6 mid-run -> new spacing applies only after the next step.
- Enable low for 10 clocks at count 2 of period 4 -> positions and count frozen; o_Active=1; after re-enable, first step 2 clocks later; i_Load in the same cycle as a due step -> loaded values, no o_Step.
- Frog_X=11, On_Lane=1, car reaches 11 -> o_Hit=1 one clock after the step; On_Lane=0 -> o_Hit=0; start X 25 -> car loads 0.
